// File: rtl/controle_multiplicador_pkg.sv
// -----------------------------------------------------------------------------
// controle_multiplicador_pkg
// Shared definitions for the ULA multiplier controller and its adder:
//   - estado_t : controller state encoding (IDLE=0, RUN=1, DONE=2)
//   - LARGURA  : operand width of the shared ripple-carry adder
//   - N_ITER   : number of add/shift iterations per product
//   - OP_MUL   : ULA opcode that the operation decoder maps to a multiply
// No ports (package).
// -----------------------------------------------------------------------------
package controle_multiplicador_pkg;

    localparam int LARGURA = 8;
    localparam int N_ITER  = 8;

    localparam logic [3:0] OP_MUL = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } estado_t;

    // Counter value seen during the last iteration.
    localparam logic [2:0] ULTIMA_ITER = 3'(N_ITER - 1);

endpackage

// File: rtl/controle_multiplicador_somador.sv
// -----------------------------------------------------------------------------
// Ripple-carry adder shared by the ULA (somadorde4bits) and its cells.
//   Meiosomador  : half adder      (a, b -> s, c)
//   SomadorPBL2  : full adder made of two half adders (a, b, cin -> s, cout)
//   somadorde4bits ports:
//     a    in  [LARGURA-1:0]  first operand
//     b    in  [LARGURA-1:0]  second operand
//     cin  in  1              carry in
//     s    out [LARGURA-1:0]  sum
//     cout out 1              carry out of the most significant cell
// -----------------------------------------------------------------------------
module Meiosomador (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module SomadorPBL2 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic w_s1;
    logic w_c1;
    logic w_c2;

    Meiosomador u_ms0 (.a(a),    .b(b),   .s(w_s1), .c(w_c1));
    Meiosomador u_ms1 (.a(w_s1), .b(cin), .s(s),    .c(w_c2));

    assign cout = w_c1 | w_c2;
endmodule

module somadorde4bits
    import controle_multiplicador_pkg::*;
(
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic               cin,
    output logic [LARGURA-1:0] s,
    output logic               cout
);
    logic [LARGURA:0] w_c;

    assign w_c[0] = cin;

    for (genvar g = 0; g < LARGURA; g++) begin : g_celula
        SomadorPBL2 u_fa (
            .a   (a[g]),
            .b   (b[g]),
            .cin (w_c[g]),
            .s   (s[g]),
            .cout(w_c[g+1])
        );
    end

    assign cout = w_c[LARGURA];
endmodule

// File: rtl/controle_multiplicador.sv
// -----------------------------------------------------------------------------
// controle_multiplicador
// Sequential 8x8 unsigned shift-and-add multiplier. One shared adder is reused
// for eight add/shift iterations; the 16-bit product is registered in P.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous, active-high reset (highest priority)
//   start      in   1   request, sampled only in IDLE
//   A          in   8   multiplicand, captured on the accepting edge
//   B          in   8   multiplier, captured on the accepting edge
//   busy       out  1   high while iterations run (state RUN)
//   done       out  1   one-cycle pulse, P valid (state DONE)
//   P          out 16   product A*B, holds until the next DONE load
//   dbg_estado out  2   current controller state
//
// Handshake: start is a request with no ready; it is accepted only on an edge
// where the controller is IDLE, and ignored otherwise (never queued). done is
// the matching one-cycle completion strobe; P stays valid after it.
// -----------------------------------------------------------------------------
module controle_multiplicador
    import controle_multiplicador_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LARGURA-1:0]   A,
    input  logic [LARGURA-1:0]   B,
    output logic                 busy,
    output logic                 done,
    output logic [2*LARGURA-1:0] P,
    output estado_t              dbg_estado
);

    estado_t                r_estado;
    estado_t                w_estado_next;

    logic [LARGURA-1:0]     r_m;
    logic [LARGURA-1:0]     r_acc;
    logic [LARGURA-1:0]     r_q;
    logic [2:0]             r_cnt;
    logic [2*LARGURA-1:0]   r_p;

    logic [LARGURA-1:0]     w_add_b;
    logic [LARGURA-1:0]     w_s;
    logic                   w_cout;
    logic [LARGURA-1:0]     w_acc_next;
    logic [LARGURA-1:0]     w_q_next;
    logic                   w_ultima;

    // Operand mux: add the multiplicand only when the current multiplier bit is 1.
    assign w_add_b = r_q[0] ? r_m : '0;

    somadorde4bits u_somador (
        .a   (r_acc),
        .b   (w_add_b),
        .cin (1'b0),
        .s   (w_s),
        .cout(w_cout)
    );

    // {Cout,S,Q} >> 1: the carry becomes ACC[7], so it is never lost.
    assign w_acc_next = {w_cout, w_s[LARGURA-1:1]};
    assign w_q_next   = {w_s[0], r_q[LARGURA-1:1]};
    assign w_ultima   = (r_cnt == ULTIMA_ITER);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            IDLE:    if (start) w_estado_next = RUN;
            RUN:     if (w_ultima) w_estado_next = DONE;
            DONE:    w_estado_next = IDLE;
            default: w_estado_next = IDLE;
        endcase
    end

    // Output decode; driven only from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_estado)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_p   <= '0;
        end else begin
            case (r_estado)
                IDLE: begin
                    if (start) begin
                        r_m   <= A;
                        r_q   <= B;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_ultima) begin
                        r_p <= {w_acc_next, w_q_next};
                    end
                end
                default: ;
            endcase
        end
    end

    assign P          = r_p;
    assign dbg_estado = r_estado;

endmodule

// File: tb/tb_controle_multiplicador.sv
module tb_controle_multiplicador;
    import controle_multiplicador_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        done;
    logic [15:0] p_out;
    estado_t     dbg_estado;

    int n_cmp;
    int n_fail;

    controle_multiplicador dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (a_in),
        .B         (b_in),
        .busy      (busy),
        .done      (done),
        .P         (p_out),
        .dbg_estado(dbg_estado)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Runs one multiply: start sampled at E0, then counts edges until done
    // (bounded), the busy-high samples, and checks the product and latency.
    task automatic run_mul(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic [15:0] exp_p);
        int n_edges;
        int n_busy;
        int n_both;
        a_in  = va;
        b_in  = vb;
        start = 1'b1;
        step();                       // E0
        start = 1'b0;
        a_in  = 8'hAA;                // operands must already be captured
        b_in  = 8'h55;
        n_edges = 0;
        n_busy  = busy ? 1 : 0;
        n_both  = 0;
        while (!done && n_edges < 20) begin
            step();
            n_edges++;
            if (busy) n_busy++;
            if (busy && done) n_both++;
        end
        check({tag, "_edges_to_done"}, 16'(n_edges), 16'd8);
        check({tag, "_busy_cycles"},   16'(n_busy),  16'd8);
        check({tag, "_busy_and_done"}, 16'(n_both),  16'd0);
        check({tag, "_p"},             p_out,        exp_p);
        step();                       // E9: back to IDLE
        check({tag, "_done_one_cycle"}, {15'd0, done}, 16'd0);
        check({tag, "_p_held"},         p_out,         exp_p);
    endtask

    initial begin
        int n_done;
        int n_busy;
        int n_edges;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = 8'd0;
        b_in   = 8'd0;

        // Reset, then idle.
        step();
        step();
        rst = 1'b0;
        check("rst_busy",  {15'd0, busy}, 16'd0);
        check("rst_done",  {15'd0, done}, 16'd0);
        check("rst_p",     p_out,         16'h0000);
        check("rst_state", {14'd0, dbg_estado}, {14'd0, IDLE});
        a_in = 8'd9;
        b_in = 8'd9;
        repeat (3) step();
        check("idle_busy",  {15'd0, busy}, 16'd0);
        check("idle_p",     p_out,         16'h0000);

        // Main products.
        run_mul("mul_13x11",   8'd13,  8'd11,  16'h008F);
        run_mul("mul_255x255", 8'd255, 8'd255, 16'hFE01);
        run_mul("mul_128x2",   8'd128, 8'd2,   16'h0100);
        run_mul("mul_0x200",   8'd0,   8'd200, 16'h0000);
        run_mul("mul_1x200",   8'd1,   8'd200, 16'h00C8);

        // Start while busy: 3x5, re-pulse with 7x7 sampled at E4.
        a_in  = 8'd3;
        b_in  = 8'd5;
        start = 1'b1;
        step();                       // E0
        start = 1'b0;
        n_done = 0;
        n_busy = busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 4) begin
                a_in  = 8'd7;
                b_in  = 8'd7;
                start = 1'b1;
            end
            step();                   // Ei
            start = 1'b0;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        check("busy_restart_done_pulses", 16'(n_done), 16'd1);
        check("busy_restart_busy_cycles", 16'(n_busy), 16'd8);
        check("busy_restart_p",           p_out,       16'h000F);

        // Reset at E5 of a 9x9 multiply.
        a_in  = 8'd9;
        b_in  = 8'd9;
        start = 1'b1;
        step();                       // E0
        start = 1'b0;
        repeat (4) step();            // E1..E4
        rst = 1'b1;
        step();                       // E5 samples rst
        rst = 1'b0;
        check("abort_state", {14'd0, dbg_estado}, {14'd0, IDLE});
        check("abort_busy",  {15'd0, busy},       16'd0);
        check("abort_p",     p_out,               16'h0000);
        n_done = 0;
        repeat (10) begin
            step();
            if (done) n_done++;
        end
        check("abort_no_done", 16'(n_done), 16'd0);
        check("abort_p_late",  p_out,       16'h0000);

        // Held start: 2x3, then re-accept at the first IDLE edge after DONE.
        a_in  = 8'd2;
        b_in  = 8'd3;
        start = 1'b1;
        step();                       // E0
        n_edges = 0;
        while (!done && n_edges < 20) begin
            step();
            n_edges++;
        end
        check("held_edges_to_done", 16'(n_edges), 16'd8);
        check("held_p",             p_out,        16'h0006);
        step();                       // E9: IDLE, start still high
        check("held_idle_busy", {15'd0, busy}, 16'd0);
        check("held_idle_done", {15'd0, done}, 16'd0);
        step();                       // E10: re-accepted
        check("held_reaccept_busy", {15'd0, busy}, 16'd1);
        start = 1'b0;
        n_edges = 0;
        while (!done && n_edges < 20) begin
            step();
            n_edges++;
        end
        check("held_second_edges", 16'(n_edges), 16'd8);
        check("held_second_p",     p_out,        16'h0006);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
